// File: rtl/cordic_point_sequencer_pkg.sv
// Shared types and constants for the CORDIC point sequencer.
package cordic_point_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_LOW,
        WAIT_HIGH,
        CALC,
        OUTPUT
    } state_t;

    localparam logic [15:0] ONE       = 16'h4000;
    localparam int          FRAC_BITS = 14;
    localparam int          DEG_FULL  = 360;
    localparam int          ANGLE_W   = 9;

endpackage

// File: rtl/cordic_point_sequencer_point_scaler.sv
// One screen axis: center +/- floor(radius * trig / ONE), clamped to the screen.
module point_scaler
    import cordic_point_sequencer_pkg::*;
#(
    parameter int COORD_W  = 10,
    parameter int RAD_W    = 8,
    parameter bit SUBTRACT = 1'b0
) (
    input  logic [RAD_W-1:0]   radius,
    input  logic [15:0]        trig,
    input  logic [COORD_W-1:0] center,
    output logic [COORD_W-1:0] coord
);

    localparam int PROD_W = RAD_W + 16;
    localparam int SUM_W  = COORD_W + 2;

    logic signed [PROD_W-1:0] rad_ext;
    logic signed [PROD_W-1:0] trig_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] delta;
    logic signed [SUM_W-1:0]  delta_s;
    logic signed [SUM_W-1:0]  center_s;
    logic signed [SUM_W-1:0]  sum;

    assign rad_ext  = PROD_W'(radius);
    assign trig_ext = PROD_W'($signed(trig));
    assign prod     = rad_ext * trig_ext;
    // Arithmetic shift rounds toward minus infinity, matching floor().
    assign delta    = prod >>> FRAC_BITS;
    assign delta_s  = SUM_W'(delta);
    assign center_s = SUM_W'(center);
    assign sum      = SUBTRACT ? (center_s - delta_s) : (center_s + delta_s);

    always_comb begin
        coord = sum[COORD_W-1:0];
        if (sum[SUM_W-1])
            coord = '0;
        else if (|sum[SUM_W-2:COORD_W])
            coord = '1;
    end

endmodule

// File: rtl/cordic_point_sequencer.sv
// Sweeps angles through the CORDIC engine and streams the resulting circle points.
module cordic_point_sequencer
    import cordic_point_sequencer_pkg::*;
#(
    parameter int COORD_W = 10,
    parameter int RAD_W   = 8,
    parameter int TIMEOUT = 63
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [8:0]         step_deg,
    input  logic [RAD_W-1:0]   radius,
    input  logic [COORD_W-1:0] center_x,
    input  logic [COORD_W-1:0] center_y,
    output logic               cordic_start,
    output logic [15:0]        cordic_angle,
    input  logic [15:0]        cordic_sine,
    input  logic [15:0]        cordic_cosine,
    input  logic               cordic_done,
    output logic               pt_valid,
    input  logic               pt_ready,
    output logic [COORD_W-1:0] pt_x,
    output logic [COORD_W-1:0] pt_y,
    output logic [8:0]         pt_angle,
    output logic               sweep_done,
    output logic               error
);

    localparam int                TCNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    state_t               state;
    logic [ANGLE_W-1:0]   angle;
    logic [RAD_W-1:0]     rad_q;
    logic [COORD_W-1:0]   cx_q;
    logic [COORD_W-1:0]   cy_q;
    logic [TCNT_W-1:0]    tcnt;
    logic [COORD_W-1:0]   x_calc;
    logic [COORD_W-1:0]   y_calc;
    logic [ANGLE_W-1:0]   step_eff;
    logic [ANGLE_W:0]     next_sum;
    logic                 wrap;
    logic [ANGLE_W-1:0]   next_angle;

    assign cordic_angle = {7'd0, angle};

    always_comb begin
        step_eff = step_deg;
        if (step_deg == '0)
            step_eff = 9'd1;
        else if (step_deg >= 9'(DEG_FULL))
            step_eff = 9'(DEG_FULL - 1);
    end

    assign next_sum   = {1'b0, angle} + {1'b0, step_eff};
    assign wrap       = next_sum >= 10'(DEG_FULL);
    assign next_angle = wrap ? 9'(next_sum - 10'(DEG_FULL)) : next_sum[ANGLE_W-1:0];

    point_scaler #(.COORD_W(COORD_W), .RAD_W(RAD_W), .SUBTRACT(1'b0)) u_scale_x (
        .radius (rad_q),
        .trig   (cordic_cosine),
        .center (cx_q),
        .coord  (x_calc)
    );

    // Screen y grows downward, so the sine term is subtracted.
    point_scaler #(.COORD_W(COORD_W), .RAD_W(RAD_W), .SUBTRACT(1'b1)) u_scale_y (
        .radius (rad_q),
        .trig   (cordic_sine),
        .center (cy_q),
        .coord  (y_calc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            angle        <= '0;
            rad_q        <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            tcnt         <= '0;
            cordic_start <= 1'b0;
            pt_valid     <= 1'b0;
            pt_x         <= '0;
            pt_y         <= '0;
            pt_angle     <= '0;
            sweep_done   <= 1'b0;
            error        <= 1'b0;
        end else begin
            cordic_start <= 1'b0;
            sweep_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && !error) begin
                        state        <= ISSUE;
                        cordic_start <= 1'b1;
                    end
                end
                ISSUE: begin
                    rad_q <= radius;
                    cx_q  <= center_x;
                    cy_q  <= center_y;
                    tcnt  <= '0;
                    state <= WAIT_LOW;
                end
                // A done still high from the previous request must drop first.
                WAIT_LOW: begin
                    tcnt <= tcnt + 1'b1;
                    if (tcnt == TCNT_LAST) begin
                        error <= 1'b1;
                        state <= IDLE;
                    end else if (!cordic_done) begin
                        state <= WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    tcnt <= tcnt + 1'b1;
                    if (cordic_done) begin
                        state <= CALC;
                    end else if (tcnt == TCNT_LAST) begin
                        error <= 1'b1;
                        state <= IDLE;
                    end
                end
                CALC: begin
                    pt_x     <= x_calc;
                    pt_y     <= y_calc;
                    pt_angle <= angle;
                    pt_valid <= 1'b1;
                    state    <= OUTPUT;
                end
                OUTPUT: begin
                    if (pt_ready) begin
                        pt_valid   <= 1'b0;
                        angle      <= next_angle;
                        sweep_done <= wrap;
                        if (enable) begin
                            state        <= ISSUE;
                            cordic_start <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
